// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage of the ALU datapath.
// Selects the ALU, shifter or HI/LO value by function code, owns the HI/LO
// registers and runs the fixed-length MULTU window during which busy is high.
// Optional feature macro: ALU_OVERLAP_ERR_EN adds a sticky overlapErr output
// that flags any op presented while the multiply window is open.
module alu_result_stage #(
  parameter int unsigned MUL_CYCLES = 32,
  parameter logic [5:0]  FC_ADD     = 6'b100000,
  parameter logic [5:0]  FC_SUB     = 6'b100010,
  parameter logic [5:0]  FC_AND     = 6'b100100,
  parameter logic [5:0]  FC_OR      = 6'b100101,
  parameter logic [5:0]  FC_SLT     = 6'b101010,
  parameter logic [5:0]  FC_SRL     = 6'b000010,
  parameter logic [5:0]  FC_MULTU   = 6'b011001,
  parameter logic [5:0]  FC_MFHI    = 6'b010000,
  parameter logic [5:0]  FC_MFLO    = 6'b010010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [5:0]  Signal,
  input  logic [31:0] aluOut,
  input  logic [31:0] shiftOut,
  input  logic [63:0] multProduct,
  output logic [31:0] dataOut,
  output logic        resultValid,
  output logic        busy
`ifdef ALU_OVERLAP_ERR_EN
  ,
  output logic        overlapErr
`endif
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  // Last count value of the window; the HI/LO load happens on that cycle.
  localparam logic [5:0] LAST_CNT = 6'(MUL_CYCLES - 1);

  state_t      state_q;
  logic [5:0]  count_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] data_q;
  logic        rv_q;
  logic        busy_q;

  logic        accept_s;
  logic        result_hit_s;
  logic        is_multu_s;
  logic [31:0] data_d;

  // Decode the function code of an accepted op into a result source.
  always_comb begin
    accept_s     = valid && (state_q == IDLE);
    result_hit_s = 1'b0;
    is_multu_s   = 1'b0;
    data_d       = data_q;
    case (Signal)
      FC_ADD, FC_SUB, FC_AND, FC_OR, FC_SLT: begin
        result_hit_s = 1'b1;
        data_d       = aluOut;
      end
      FC_SRL: begin
        result_hit_s = 1'b1;
        data_d       = shiftOut;
      end
      FC_MFHI: begin
        result_hit_s = 1'b1;
        data_d       = hi_q;
      end
      FC_MFLO: begin
        result_hit_s = 1'b1;
        data_d       = lo_q;
      end
      FC_MULTU: begin
        is_multu_s = 1'b1;
      end
      default: begin
        // Unknown code: nothing is produced, output holds.
        result_hit_s = 1'b0;
      end
    endcase
  end

  // Control FSM plus result, HI/LO and busy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      data_q  <= 32'd0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_s && result_hit_s) begin
            data_q <= data_d;
            rv_q   <= 1'b1;
          end else if (accept_s && is_multu_s) begin
            state_q <= MUL_WAIT;
            count_q <= 6'd0;
            busy_q  <= 1'b1;
          end
        end
        MUL_WAIT: begin
          // Any op offered here is dropped; only the counter advances.
          if (count_q == LAST_CNT) begin
            hi_q    <= multProduct[63:32];
            lo_q    <= multProduct[31:0];
            count_q <= 6'd0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            count_q <= count_q + 6'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= 6'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dataOut     = data_q;
  assign resultValid = rv_q;
  assign busy        = busy_q;

`ifdef ALU_OVERLAP_ERR_EN
  logic ovl_q;

  // Sticky flag: an op was offered while the multiply window was open.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovl_q <= 1'b0;
    end else if (valid && busy_q) begin
      ovl_q <= 1'b1;
    end
  end

  assign overlapErr = ovl_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: the stimulus thread pushes the
// expected dataOut of each result op, a monitor pops on every resultValid.
module tb_alu_result_stage;

  localparam logic [5:0] FC_ADD   = 6'b100000;
  localparam logic [5:0] FC_SRL   = 6'b000010;
  localparam logic [5:0] FC_MULTU = 6'b011001;
  localparam logic [5:0] FC_MFHI  = 6'b010000;
  localparam logic [5:0] FC_MFLO  = 6'b010010;

  logic        clk;
  logic        reset;
  logic        valid;
  logic [5:0]  Signal;
  logic [31:0] aluOut;
  logic [31:0] shiftOut;
  logic [63:0] multProduct;
  logic [31:0] dataOut;
  logic        resultValid;
  logic        busy;
`ifdef ALU_OVERLAP_ERR_EN
  logic        overlapErr;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  alu_result_stage #(.MUL_CYCLES(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid       (valid),
    .Signal      (Signal),
    .aluOut      (aluOut),
    .shiftOut    (shiftOut),
    .multProduct (multProduct),
    .dataOut     (dataOut),
    .resultValid (resultValid),
    .busy        (busy)
`ifdef ALU_OVERLAP_ERR_EN
    ,
    .overlapErr  (overlapErr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every resultValid pulse must match the oldest expected value.
  always @(negedge clk) begin
    if (reset === 1'b1 && resultValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_resultValid: got dataOut %h expected no result", dataOut);
      end else begin
        check("scoreboard_dataOut", {32'd0, dataOut}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  // One-cycle op presented at a falling edge; returns at the next falling edge.
  task automatic do_op(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] s,
                       input bit has_result, input logic [31:0] exp);
    valid    = 1'b1;
    Signal   = sig;
    aluOut   = a;
    shiftOut = s;
    if (has_result) exp_q.push_back(exp);
    @(negedge clk);
    valid = 1'b0;
  endtask

  // MULTU, then count busy cycles; optionally inject an op or assert reset
  // on window cycle inject_at / rst_at (1-based).
  task automatic run_multu(input logic [63:0] prod, input int inject_at, input int rst_at,
                           output int nbusy);
    multProduct = prod;
    valid  = 1'b1;
    Signal = FC_MULTU;
    @(negedge clk);
    valid = 1'b0;
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 100) begin
      nbusy++;
      if (nbusy == inject_at) begin
        valid  = 1'b1;
        Signal = FC_ADD;
        aluOut = 32'h0000_DEAD;
      end
      if (nbusy == rst_at) begin
        reset = 1'b0;
        #1;
        check("busy_drops_on_reset", {63'd0, busy}, 64'd0);
        break;
      end
      @(negedge clk);
      valid = 1'b0;
    end
  endtask

  initial begin
    int nb;
    reset       = 1'b0;
    valid       = 1'b0;
    Signal      = 6'd0;
    aluOut      = 32'd0;
    shiftOut    = 32'd0;
    multProduct = 64'd0;
    @(negedge clk);
    @(negedge clk);
    check("reset_dataOut", {32'd0, dataOut}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_resultValid", {63'd0, resultValid}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // SRL result, then resultValid must be a single-cycle pulse.
    do_op(FC_SRL, 32'h1111_1111, 32'h0000_00F0, 1'b1, 32'h0000_00F0);
    @(negedge clk);
    check("srl_pulse_width", {63'd0, resultValid}, 64'd0);
    check("srl_hold", {32'd0, dataOut}, 64'h0000_00F0);

    // ADD result, then five idle cycles of hold.
    do_op(FC_ADD, 32'h0000_0007, 32'h2222_2222, 1'b1, 32'h0000_0007);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_hold_dataOut", {32'd0, dataOut}, 64'h0000_0007);
      check("idle_resultValid", {63'd0, resultValid}, 64'd0);
    end

    // Clean multiply window: exactly 32 busy cycles, then MFHI/MFLO.
    run_multu(64'h0000_0001_FFFF_FFFE, 0, 0, nb);
    check("multu_busy_cycles", 64'(nb), 64'd32);
    check("multu_no_result", {32'd0, dataOut}, 64'h0000_0007);
    do_op(FC_MFHI, 32'd0, 32'd0, 1'b1, 32'h0000_0001);
    do_op(FC_MFLO, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFE);
`ifdef ALU_OVERLAP_ERR_EN
    check("overlap_clear", {63'd0, overlapErr}, 64'd0);
`endif

    // ADD offered on cycle 10 of the window is dropped.
    run_multu(64'h1234_5678_9ABC_DEF0, 10, 0, nb);
    check("overlap_busy_cycles", 64'(nb), 64'd32);
    check("overlap_dataOut_held", {32'd0, dataOut}, 64'hFFFF_FFFE);
    do_op(FC_MFHI, 32'd0, 32'd0, 1'b1, 32'h1234_5678);
    do_op(FC_MFLO, 32'd0, 32'd0, 1'b1, 32'h9ABC_DEF0);
`ifdef ALU_OVERLAP_ERR_EN
    check("overlap_sticky", {63'd0, overlapErr}, 64'd1);
`endif

    // Reset on cycle 15 of a window abandons the multiply.
    run_multu(64'hCAFE_F00D_BEEF_1234, 0, 15, nb);
    @(negedge clk);
    check("midreset_dataOut", {32'd0, dataOut}, 64'd0);
    check("midreset_busy", {63'd0, busy}, 64'd0);
`ifdef ALU_OVERLAP_ERR_EN
    check("midreset_overlap", {63'd0, overlapErr}, 64'd0);
`endif
    reset = 1'b1;
    @(negedge clk);
    do_op(FC_MFHI, 32'd0, 32'd0, 1'b1, 32'h0000_0000);
    do_op(FC_MFLO, 32'd0, 32'd0, 1'b1, 32'h0000_0000);
    @(negedge clk);
    check("post_reset_busy", {63'd0, busy}, 64'd0);

    // Unknown function code: output held, no pulse, not busy.
    do_op(FC_ADD, 32'h0000_0055, 32'd0, 1'b1, 32'h0000_0055);
    do_op(6'b111111, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 1'b0, 32'd0);
    check("unknown_resultValid", {63'd0, resultValid}, 64'd0);
    check("unknown_dataOut", {32'd0, dataOut}, 64'h0000_0055);
    check("unknown_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered result stage directly downstream of the barrel shifter and the arithmetic/logic unit; sits at the output of the ALU datapath.
- Selects among the arithmetic/logic result, the shifter result and the HI/LO registers according to the 6-bit function code `Signal`.
- Owns the HI/LO registers and sequences the multi-cycle MULTU window, reporting `busy` while the multiplier result settles.

Parameters:
- MUL_CYCLES, 32: cycles from MULTU acceptance to the HI/LO update; legal range 1..63.
- FC_ADD, 6'b100000: function code ADD, result from aluOut.
- FC_SUB, 6'b100010: function code SUB, result from aluOut.
- FC_AND, 6'b100100: function code AND, result from aluOut.
- FC_OR, 6'b100101: function code OR, result from aluOut.
- FC_SLT, 6'b101010: function code SLT, result from aluOut.
- FC_SRL, 6'b000010: function code SRL, result from shiftOut.
- FC_MULTU, 6'b011001: function code MULTU, starts the multiply window.
- FC_MFHI, 6'b010000: function code MFHI, result from HI.
- FC_MFLO, 6'b010010: function code MFLO, result from LO.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- valid  input  1  one-cycle qualifier: Signal and the operands are valid this cycle.
- Signal  input  6  function code.
- aluOut  input  32  combinational ALU result.
- shiftOut  input  32  combinational shifter result.
- multProduct  input  64  multiplier product, stable by the end of the MULTU window.
- dataOut  output  32  registered result.
- resultValid  output  1  one-cycle pulse: dataOut updated.
- busy  output  1  high while the multiply window is open.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, count=0.
  - HI=0, LO=0, dataOut=0, resultValid=0, busy=0.
  - Reset mid-window abandons the multiply; HI/LO stay 0.
- States:
  - IDLE: busy=0.
  - MUL_WAIT: busy=1 (busy is a registered state decode).
- Acceptance: an operation is accepted only when valid=1 and state=IDLE.
- Latency: accepted result op -> dataOut loaded and resultValid=1 on the next rising edge; resultValid lasts exactly 1 cycle.
- Result selection on acceptance:
  - ADD/SUB/AND/OR/SLT -> aluOut.
  - SRL -> shiftOut.
  - MFHI -> HI; MFLO -> LO.
- MULTU accepted:
  - IDLE->MUL_WAIT, count=0.
  - dataOut unchanged, resultValid=0.
- MUL_WAIT:
  - count increments each cycle.
  - When count==MUL_CYCLES-1: HI<=multProduct[63:32], LO<=multProduct[31:0], count<=0, state->IDLE.
  - busy therefore stays high for exactly MUL_CYCLES cycles.
- valid during MUL_WAIT, including the final cycle: operation dropped, no resultValid, no state change. Issuing ops while busy is the caller's responsibility.
- MFHI/MFLO accepted on the first cycle after busy falls return the new HI/LO.
- Unknown function code accepted: dataOut held, resultValid=0, state unchanged.
- valid=0: dataOut, HI and LO hold their values.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: ALU_OVERLAP_ERR_EN.
- Defined:
  - Adds output port overlapErr (1 bit).
  - overlapErr is sticky; it sets on the edge after any cycle with valid=1 and busy=1.
  - Cleared only by reset (value 0).
- Undefined: the port is absent; dropped ops are silent. All other behaviour is identical.

Test Plan:
- Reset -> dataOut=0, busy=0, resultValid=0. Then valid, Signal=FC_SRL, shiftOut=32'h0000_00F0 -> next edge dataOut=32'h0000_00F0, resultValid=1 for 1 cycle.
- valid, Signal=FC_ADD, aluOut=32'h0000_0007 -> dataOut=32'h0000_0007 after 1 cycle. Then valid=0 for 5 cycles -> dataOut holds, resultValid=0.
- MULTU with multProduct=64'h0000_0001_FFFF_FFFE, MUL_CYCLES=32:
  - busy=1 for exactly 32 cycles.
  - Then MFHI -> dataOut=32'h0000_0001.
  - Then MFLO -> dataOut=32'hFFFF_FFFE.
- valid FC_ADD at cycle 10 of a MULTU window -> no resultValid, dataOut unchanged, busy still falls at cycle 32. With ALU_OVERLAP_ERR_EN, overlapErr=1 and stays 1.
- Assert reset=0 at cycle 15 of a MULTU window -> busy=0 immediately, HI=LO=0. A following MFHI returns 0.
- valid with Signal=6'b111111 -> dataOut unchanged, resultValid=0, busy=0.
